sigmoid_taylor: RTL and testbench
=================================

Name: sigmoid_taylor

Overview:
- Fixed-point logistic-sigmoid unit: f_x = 1/(1+e^-x) for a signed Q4.8 input, result in unsigned Q1.12.
- Uses a piecewise second-order Taylor expansion over |x|, plus the identity sig(-x) = 1 - sig(x).
- Single registered output stage (one-cycle latency); sits in the activation path of the datapath.

Parameters:
- none (all widths fixed: input 12 bits, output 13 bits)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- x  input  12  signed two's complement Q4.8 (range -8.0 .. +7.99609375, LSB 2^-8)
- f_x  output  13  unsigned Q1.12; bit 12 is the integer bit, bits 11:0 are the fraction (LSB 2^-12)

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - reset=1 at an edge forces f_x to 0 on that edge; reset has priority over x.
  - Reset mid-stream discards the computation of that cycle.
- Latency: f_x at the output after edge N reflects x sampled at edge N (x captured combinationally, result registered). Fully pipelined: a new x is accepted every cycle; there is no handshake.
- Magnitude: a = |x| as unsigned Q3.8 (11 bits).
- Special case x = 0x800 (-8.0): f_x = 0x0000.
- Segmentation: a is split into 8 segments of width 1.0, index s = a[10:8], with center c_s = s + 0.5.
- Coefficient ROM (8 entries, indexed by s):
  - k0 = sig(c_s), k1 = sig'(c_s), k2 = sig''(c_s)/2.
  - Each coefficient is quantized to signed Q1.16, round-to-nearest.
- Evaluation:
  - d = a - c_s, signed, range [-0.5, +0.5), exact in Q0.8.
  - g = k0 + k1*d + k2*d*d.
  - Keep full-precision intermediates; no truncation before the final rounding.
- Output formatting:
  - Round g to Q1.12, round-half-up, then saturate to [0x0000, 0x1000].
  - x >= 0 (sign bit 0): f_x = g.
  - x < 0 (and x != 0x800): f_x = 0x1000 - g.
  - x = 0 must yield exactly 0x0800. Guarantee this by forcing g(0) = 0x800.
- Symmetry: for every x != 0x800, f_x(x) + f_x(-x) = 0x1000 exactly.
- Accuracy over all 4095 inputs other than 0x800:
  - |f_x - sig(x)| <= 16 LSB (0.0039).
  - Mean absolute error <= 4 LSB.
- Monotonic: f_x is non-decreasing in signed x.
- Range: f_x never exceeds 0x1000, so f_x[12]=1 only when f_x = 0x1000.

Test Plan:
- Reset: hold reset=1 for 2 edges with x=0x280 -> f_x=0x0000. Release; after 1 edge f_x tracks x.
- Spot points, each checked 1 cycle after applying x, tolerance ±16 LSB:
  - x=0x000 -> 0x0800 exactly.
  - x=0x100 (+1.0) -> 0x0BB2.
  - x=0x280 (+2.5) -> 0x0ECA.
  - x=0x300 (+3.0) -> 0x0F3E.
  - x=0xD00 (-3.0) -> 0x00C2.
- Symmetry and edge values:
  - For x=0x300/0xD00 and x=0x001/0xFFF, the two outputs sum to 0x1000.
  - x=0x800 -> 0x0000.
  - x=0x7FF -> 0x0FFE (±16 LSB).
- Exhaustive sweep:
  - Apply x = 0x000..0xFFF, one value per cycle, back-to-back.
  - Compare each result (latency 1) against real sigmoid.
  - Max error <= 16 LSB, mean absolute error <= 4 LSB, output monotonic in signed x.
- Segment boundaries: x = 0x0FF/0x100, 0x1FF/0x200, ... 0x6FF/0x700 -> step between neighbours <= 16 LSB and non-negative.
- Back-to-back throughput: alternate x=0x100 and x=0xF00 every cycle -> f_x alternates 0x0BB2 / 0x044E (±16 LSB) with no bubbles.

Source files
------------

// File: rtl/sigmoid_taylor.sv
// Logistic sigmoid, signed Q4.8 in -> unsigned Q1.12 out, one-cycle latency.
// Piecewise 2nd-order Taylor about segment centres on |x|, mirrored for x < 0.
module sigmoid_taylor (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] x,
    output logic [12:0] f_x
);

    localparam logic [12:0] ONE  = 13'h1000;
    localparam logic [12:0] HALF = 13'h0800;
    localparam logic signed [39:0] RND = 40'sd524288;

    logic               neg;
    logic               min_neg;
    logic [10:0]        mag;
    logic [2:0]         seg;
    logic signed [8:0]  d;
    logic signed [17:0] dd;
    logic signed [17:0] k0;
    logic signed [17:0] k1;
    logic signed [17:0] k2;
    logic [12:0]        lo;
    logic [12:0]        hi;
    logic signed [26:0] p1;
    logic signed [35:0] p2;
    logic signed [39:0] acc;
    logic signed [19:0] g_r;
    logic [12:0]        g_sat;
    logic [12:0]        g;
    logic [12:0]        f_x_d;
    logic [12:0]        f_x_q;

    always_comb begin
        neg     = x[11];
        min_neg = (x == 12'h800);
        mag     = neg ? (~x[10:0] + 11'd1) : x[10:0];
        seg     = mag[10:8];
        d       = $signed({1'b0, mag[7:0]}) - 9'sd128;
        dd      = 18'(d) * 18'(d);
    end

    // Q1.16 Taylor terms at c = s + 0.5: sig, sig', sig''/2.
    // lo/hi pin each segment between its neighbours' joins,
    // which keeps the curve monotonic across segment edges.
    always_comb begin
        k0 = '0;
        k1 = '0;
        k2 = '0;
        lo = HALF;
        hi = ONE;
        unique case (seg)
            3'd0: begin
                k0 = 18'sd40793; k1 = 18'sd15401; k2 = -18'sd1886;
                lo = 13'd2048;   hi = 13'd2995;
            end
            3'd1: begin
                k0 = 18'sd53581; k1 = 18'sd9774;  k2 = -18'sd3104;
                lo = 13'd2995;   hi = 13'd3611;
            end
            3'd2: begin
                k0 = 18'sd60565; k1 = 18'sd4594;  k2 = -18'sd1949;
                lo = 13'd3611;   hi = 13'd3904;
            end
            3'd3: begin
                k0 = 18'sd63615; k1 = 18'sd1865;  k2 = -18'sd878;
                lo = 13'd3904;   hi = 13'd4023;
            end
            3'd4: begin
                k0 = 18'sd64816; k1 = 18'sd712;   k2 = -18'sd348;
                lo = 13'd4023;   hi = 13'd4069;
            end
            3'd5: begin
                k0 = 18'sd65269; k1 = 18'sd266;   k2 = -18'sd132;
                lo = 13'd4069;   hi = 13'd4086;
            end
            3'd6: begin
                k0 = 18'sd65438; k1 = 18'sd98;    k2 = -18'sd49;
                lo = 13'd4086;   hi = 13'd4092;
            end
            3'd7: begin
                k0 = 18'sd65500; k1 = 18'sd36;    k2 = -18'sd18;
                lo = 13'd4092;   hi = 13'd4096;
            end
        endcase
    end

    // All terms aligned to 2^-32 before a single round to 2^-12.
    always_comb begin
        p1  = 27'(k1) * 27'(d);
        p2  = 36'(k2) * 36'(dd);
        acc = (40'(k0) <<< 16) + (40'(p1) <<< 8) + 40'(p2) + RND;
        g_r = 20'(acc >>> 20);
    end

    always_comb begin
        if (g_r < 20'sd0) begin
            g_sat = 13'd0;
        end else if (g_r > 20'sd4096) begin
            g_sat = ONE;
        end else begin
            g_sat = g_r[12:0];
        end
        if (g_sat < lo) begin
            g = lo;
        end else if (g_sat > hi) begin
            g = hi;
        end else begin
            g = g_sat;
        end
        if (mag == 11'd0) begin
            g = HALF;
        end
    end

    always_comb begin
        if (min_neg) begin
            f_x_d = 13'd0;
        end else if (neg) begin
            f_x_d = ONE - g;
        end else begin
            f_x_d = g;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_x_q <= 13'd0;
        end else begin
            f_x_q <= f_x_d;
        end
    end

    assign f_x = f_x_q;

endmodule

// File: tb/tb_sigmoid_taylor.sv
// Bench for sigmoid_taylor: directed points, random points against a real
// sigmoid model, and a full back-to-back sweep with error/monotonic stats.
module tb_sigmoid_taylor;

    logic        clk;
    logic        reset;
    logic [11:0] x;
    logic [12:0] f_x;

    int total;
    int bad;
    int res [4096];

    sigmoid_taylor dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .f_x   (f_x)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic real model(input int v);
        int  sv;
        real xr;
        sv = (v >= 2048) ? v - 4096 : v;
        xr = sv / 256.0;
        return 4096.0 / (1.0 + $exp(-xr));
    endfunction

    task automatic step(input logic [11:0] v, output logic [12:0] r);
        x = v;
        @(posedge clk);
        #1;
        r = f_x;
    endtask

    task automatic chk_tol(input string tag, input int got,
                           input real want, input real tol);
        real diff;
        diff = got - want;
        if (diff < 0.0) diff = -diff;
        total++;
        assert ((diff <= tol) === 1'b1) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0.2f tol=%0.1f",
                   tag, got, want, tol);
        end
    endtask

    task automatic chk_eq(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic chk_le(input string tag, input real got, input real lim);
        total++;
        assert ((got <= lim) === 1'b1) else begin
            bad++;
            $error("FAIL %s got=%0.3f limit=%0.3f", tag, got, lim);
        end
    endtask

    initial begin
        logic [12:0] r;
        logic [12:0] r2;
        int          v;
        int          mono_bad;
        int          sym_bad;
        int          lo_v;
        int          hi_v;
        int          step_bad;
        real         err;
        real         max_err;
        real         sum_err;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        x     = 12'h280;

        @(posedge clk);
        #1;
        chk_eq("reset_edge1", int'(f_x), 0);
        @(posedge clk);
        #1;
        chk_eq("reset_edge2", int'(f_x), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_tol("release_0x280", int'(f_x), 3786.0, 16.0);

        step(12'h000, r);
        chk_eq("zero_exact", int'(r), 2048);
        step(12'h100, r);
        chk_tol("x_0x100", int'(r), 2994.0, 16.0);
        step(12'h280, r);
        chk_tol("x_0x280", int'(r), 3786.0, 16.0);
        step(12'h300, r);
        chk_tol("x_0x300", int'(r), 3902.0, 16.0);
        step(12'hD00, r2);
        chk_tol("x_0xD00", int'(r2), 194.0, 16.0);
        chk_eq("sym_0x300", int'(r) + int'(r2), 4096);
        step(12'h001, r);
        step(12'hFFF, r2);
        chk_eq("sym_0x001", int'(r) + int'(r2), 4096);
        step(12'h800, r);
        chk_eq("min_neg", int'(r), 0);
        step(12'h7FF, r);
        chk_tol("x_0x7FF", int'(r), 4094.0, 16.0);

        // reset mid-stream discards that cycle's result
        reset = 1'b1;
        step(12'h300, r);
        chk_eq("reset_mid", int'(r), 0);
        reset = 1'b0;
        step(12'h300, r);
        chk_tol("after_mid_reset", int'(r), 3902.0, 16.0);

        for (int i = 0; i < 300; i++) begin
            v = int'($urandom_range(0, 4095));
            step(12'(v), r);
            if (v == 2048) begin
                chk_eq("rand_min_neg", int'(r), 0);
            end else begin
                chk_tol($sformatf("rand_%03h", v), int'(r), model(v), 16.0);
            end
        end

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(1, 2047));
            step(12'(v), r);
            step(12'(4096 - v), r2);
            chk_eq($sformatf("rand_sym_%03h", v), int'(r) + int'(r2), 4096);
        end

        for (int i = 0; i < 16; i++) begin
            step((i % 2 == 0) ? 12'h100 : 12'hF00, r);
            if (i % 2 == 0) begin
                chk_tol("alt_0x100", int'(r), 2994.0, 16.0);
            end else begin
                chk_tol("alt_0xF00", int'(r), 1102.0, 16.0);
            end
        end

        for (int i = 0; i < 4096; i++) begin
            step(12'(i), r);
            res[i] = int'(r);
        end

        max_err = 0.0;
        sum_err = 0.0;
        sym_bad = 0;
        for (int i = 0; i < 4096; i++) begin
            if (i != 2048) begin
                err = res[i] - model(i);
                if (err < 0.0) err = -err;
                if (err > max_err) max_err = err;
                sum_err += err;
                if (res[i] + res[(4096 - i) % 4096] != 4096) sym_bad++;
            end
        end
        chk_eq("sweep_min_neg", res[2048], 0);
        chk_eq("sweep_zero", res[0], 2048);
        chk_le("sweep_max_err", max_err, 16.0);
        chk_le("sweep_mean_err", sum_err / 4095.0, 4.0);
        chk_eq("sweep_sym_viol", sym_bad, 0);

        mono_bad = 0;
        for (int s = -2047; s <= 2047; s++) begin
            if (res[s & 4095] < res[(s - 1) & 4095]) mono_bad++;
        end
        chk_eq("sweep_mono_viol", mono_bad, 0);

        for (int s = 1; s < 8; s++) begin
            lo_v = res[s * 256 - 1];
            hi_v = res[s * 256];
            step_bad = ((hi_v >= lo_v) && (hi_v - lo_v <= 16)) ? 0 : 1;
            chk_eq($sformatf("seg_edge_%0d_%0d_%0d", s, lo_v, hi_v),
                   step_bad, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
